uart_rx_frame: RTL and testbench

Parametrised UART receiver and successor to the fixed 8N2 receiver. It runs on the system clock and uses a one-cycle oversampling strobe from the baud generator. Data width, oversampling ratio and stop-bit count are set at build time; parity mode is selected at run time. It adds input synchronisation, false-start rejection, parity/framing/break/overrun detection, and a valid/read handshake toward the consumer (FIFO or ALU-interface FSM).

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_frame.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receive path.
// FSM state encoding, parity mode decode and a constant log2 helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } par_mode_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Encoding 2'b11 is reserved and behaves as no parity.
   function automatic par_mode_t decode_par(input logic [1:0] mode);
      par_mode_t result;
      case (mode)
         2'b01:   result = PAR_EVEN;
         2'b10:   result = PAR_ODD;
         default: result = PAR_NONE;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both stages reset to RST_VAL so an idle-high line does not look like a start bit.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_async,
   output logic o_sync
);

   logic meta;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         meta   <= RST_VAL;
         o_sync <= RST_VAL;
      end else begin
         meta   <= i_async;
         o_sync <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: synchronised input, false-start rejection,
// parity/framing/break/overrun flags and a sticky valid/read handshake.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int unsigned NB_DATA    = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned NB_STOP    = 1,
   parameter int unsigned NB_TICK    = clog2(OVERSAMPLE),
   parameter int unsigned NB_BITCNT  = clog2(NB_DATA + 1)
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_s_tick,
   input  logic               i_rx,
   input  logic [1:0]         i_parity_mode,
   input  logic               i_read,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_valid,
   output logic               o_rx_done_tick,
   output logic               o_parity_err,
   output logic               o_frame_err,
   output logic               o_break,
   output logic               o_overrun,
   output logic               o_busy
);

   localparam logic [NB_TICK-1:0]   TICK_MID  = NB_TICK'(OVERSAMPLE / 2 - 1);
   localparam logic [NB_TICK-1:0]   TICK_END  = NB_TICK'(OVERSAMPLE - 1);
   localparam logic [NB_BITCNT-1:0] BIT_LAST  = NB_BITCNT'(NB_DATA - 1);
   localparam logic                 STOP_LAST = 1'(NB_STOP - 1);

   logic rx_s;

   uart_sync2 #(
      .RST_VAL (1'b1)
   ) u_rx_sync (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_async (i_rx),
      .o_sync  (rx_s)
   );

   state_t               state,    state_n;
   logic [NB_TICK-1:0]   tick_cnt, tick_n;
   logic [NB_BITCNT-1:0] bit_cnt,  bit_n;
   logic                 stop_cnt, stop_n;
   logic [NB_DATA-1:0]   shift,    shift_n;
   logic                 xor_acc,  xor_n;
   par_mode_t            par_mode, mode_n;
   logic                 par_err,  perr_n;
   logic                 frm_err,  ferr_n;
   logic                 finish;

   logic [NB_DATA-1:0]   data_q;
   logic                 done_q;
   logic                 perr_q;
   logic                 ferr_q;
   logic                 brk_q;
   logic                 valid_q;
   logic                 ovr_q;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         shift    <= '0;
         xor_acc  <= 1'b0;
         par_mode <= PAR_NONE;
         par_err  <= 1'b0;
         frm_err  <= 1'b0;
      end else begin
         state    <= state_n;
         tick_cnt <= tick_n;
         bit_cnt  <= bit_n;
         stop_cnt <= stop_n;
         shift    <= shift_n;
         xor_acc  <= xor_n;
         par_mode <= mode_n;
         par_err  <= perr_n;
         frm_err  <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      tick_n  = tick_cnt;
      bit_n   = bit_cnt;
      stop_n  = stop_cnt;
      shift_n = shift;
      xor_n   = xor_acc;
      mode_n  = par_mode;
      perr_n  = par_err;
      ferr_n  = frm_err;
      finish  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               tick_n  = '0;
               bit_n   = '0;
               stop_n  = 1'b0;
               xor_n   = 1'b0;
               perr_n  = 1'b0;
               ferr_n  = 1'b0;
               mode_n  = decode_par(i_parity_mode);
            end
         end
         START: begin
            if (i_s_tick) begin
               if (tick_cnt == TICK_MID) begin
                  tick_n  = '0;
                  state_n = rx_s ? IDLE : DATA;
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (i_s_tick) begin
               if (tick_cnt == TICK_END) begin
                  tick_n  = '0;
                  shift_n = {rx_s, shift[NB_DATA-1:1]};
                  xor_n   = xor_acc ^ rx_s;
                  bit_n   = bit_cnt + 1'b1;
                  if (bit_cnt == BIT_LAST) begin
                     state_n = (par_mode == PAR_NONE) ? STOP : PARITY;
                  end
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
         end
         PARITY: begin
            if (i_s_tick) begin
               if (tick_cnt == TICK_END) begin
                  tick_n  = '0;
                  perr_n  = ((xor_acc ^ rx_s) != (par_mode == PAR_ODD));
                  state_n = STOP;
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (i_s_tick) begin
               if (tick_cnt == TICK_END) begin
                  tick_n = '0;
                  ferr_n = frm_err | ~rx_s;
                  if (stop_cnt == STOP_LAST) begin
                     state_n = IDLE;
                     finish  = 1'b1;
                  end else begin
                     stop_n = stop_cnt + 1'b1;
                  end
               end else begin
                  tick_n = tick_cnt + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Result registers load on the last stop sample, so they and done_q change
   // together; valid/overrun resolve one cycle later so i_read during the done
   // cycle is seen as consuming the previous word.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         data_q  <= '0;
         done_q  <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         brk_q   <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         done_q <= finish;
         if (finish) begin
            data_q <= shift;
            perr_q <= (par_mode != PAR_NONE) && par_err;
            ferr_q <= ferr_n;
            brk_q  <= (shift == '0) && ferr_n;
         end
         if (done_q) begin
            valid_q <= 1'b1;
            ovr_q   <= valid_q && !i_read;
         end else if (i_read) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
         end
      end
   end

   assign o_data         = data_q;
   assign o_valid        = valid_q | done_q;
   assign o_rx_done_tick = done_q;
   assign o_parity_err   = perr_q;
   assign o_frame_err    = ferr_q;
   assign o_break        = brk_q;
   assign o_overrun      = ovr_q;
   assign o_busy         = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: 8 data bits, x16 oversampling, one stop bit,
// i_s_tick every 27 clocks.
module tb_uart_rx_frame;

   localparam int TICK_DIV = 27;
   localparam int BIT_CLKS = 16 * TICK_DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_tick = 1'b0;
   logic       rx;
   logic [1:0] pmode;
   logic       rd;

   logic [7:0] data;
   logic       valid, done, perr, ferr, brk, ovr, busy;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int div_cnt = 0;
   int d0;

   logic [7:0] cap_data;
   logic       cap_valid, cap_perr, cap_ferr, cap_brk, cap_ovr;

   uart_rx_frame #(
      .NB_DATA    (8),
      .OVERSAMPLE (16),
      .NB_STOP    (1)
   ) dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_s_tick       (s_tick),
      .i_rx           (rx),
      .i_parity_mode  (pmode),
      .i_read         (rd),
      .o_data         (data),
      .o_valid        (valid),
      .o_rx_done_tick (done),
      .o_parity_err   (perr),
      .o_frame_err    (ferr),
      .o_break        (brk),
      .o_overrun      (ovr),
      .o_busy         (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (div_cnt == TICK_DIV - 1) begin
         div_cnt = 0;
         s_tick  = 1'b1;
      end else begin
         div_cnt = div_cnt + 1;
         s_tick  = 1'b0;
      end
   end

   // Snapshot of the outputs in each done cycle
   always @(negedge clk) begin
      if (done) begin
         done_cnt  = done_cnt + 1;
         cap_data  = data;
         cap_valid = valid;
         cap_perr  = perr;
         cap_ferr  = ferr;
         cap_brk   = brk;
         cap_ovr   = ovr;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b, input bit rd_on_done);
      rx = b;
      repeat (BIT_CLKS) begin
         @(negedge clk);
         if (rd_on_done) rd = done;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit use_par, input logic pbit,
                             input bit rd_on_done, input int switch_at);
      logic [10:0] bits;
      int n;
      bits      = '1;
      bits[0]   = 1'b0;
      bits[8:1] = d;
      n = 10;
      if (use_par) begin
         bits[9] = pbit;
         n = 11;
      end
      for (int i = 0; i < n; i++) begin
         if (i == switch_at) pmode = 2'b00;
         send_bit(bits[i], rd_on_done);
      end
      rd = 1'b0;
   endtask

   task automatic read_pulse();
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"},  32'(data),  32'h0);
      chk({tag, "_valid"}, 32'(valid), 32'h0);
      chk({tag, "_done"},  32'(done),  32'h0);
      chk({tag, "_perr"},  32'(perr),  32'h0);
      chk({tag, "_ferr"},  32'(ferr),  32'h0);
      chk({tag, "_brk"},   32'(brk),   32'h0);
      chk({tag, "_ovr"},   32'(ovr),   32'h0);
      chk({tag, "_busy"},  32'(busy),  32'h0);
   endtask

   initial begin
      rst   = 1'b1;
      rx    = 1'b1;
      pmode = 2'b00;
      rd    = 1'b0;
      repeat (4) @(negedge clk);
      chk_all_zero("rst");
      rst = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);

      // 0x55, no parity
      d0 = done_cnt;
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
      chk("f55_done",  32'(done_cnt - d0), 32'd1);
      chk("f55_data",  32'(cap_data),  32'h55);
      chk("f55_valid", 32'(cap_valid), 32'h1);
      chk("f55_perr",  32'(cap_perr),  32'h0);
      chk("f55_ferr",  32'(cap_ferr),  32'h0);
      chk("f55_brk",   32'(cap_brk),   32'h0);
      chk("f55_ovr",   32'(cap_ovr),   32'h0);
      chk("f55_valid_held", 32'(valid), 32'h1);
      read_pulse();
      chk("f55_read_clr", 32'(valid), 32'h0);

      // Even parity on 0xA3 (four ones): bit 0 correct, bit 1 wrong
      pmode = 2'b01;
      send_frame(8'hA3, 1'b1, 1'b0, 1'b0, -1);
      chk("even_ok_perr", 32'(cap_perr), 32'h0);
      chk("even_ok_ferr", 32'(cap_ferr), 32'h0);
      read_pulse();
      d0 = done_cnt;
      send_frame(8'hA3, 1'b1, 1'b1, 1'b0, -1);
      chk("even_bad_done", 32'(done_cnt - d0), 32'd1);
      chk("even_bad_perr", 32'(cap_perr), 32'h1);
      chk("even_bad_data", 32'(cap_data), 32'hA3);
      read_pulse();

      // Odd parity latched at start; mode switched to none during data
      pmode = 2'b10;
      d0 = done_cnt;
      send_frame(8'hA3, 1'b1, 1'b1, 1'b0, 3);
      chk("odd_ok_done", 32'(done_cnt - d0), 32'd1);
      chk("odd_ok_perr", 32'(cap_perr), 32'h0);
      chk("odd_ok_data", 32'(cap_data), 32'hA3);
      read_pulse();
      pmode = 2'b10;
      send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 3);
      chk("odd_bad_perr", 32'(cap_perr), 32'h1);
      chk("odd_bad_ferr", 32'(cap_ferr), 32'h0);
      read_pulse();
      pmode = 2'b00;
      repeat (BIT_CLKS) @(negedge clk);

      // 5-tick low glitch, then a real 0x3C frame
      d0 = done_cnt;
      rx = 1'b0;
      repeat (3 * TICK_DIV) @(negedge clk);
      chk("glitch_busy_hi", 32'(busy), 32'h1);
      repeat (2 * TICK_DIV) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk("glitch_no_done", 32'(done_cnt - d0), 32'd0);
      chk("glitch_busy_lo", 32'(busy), 32'h0);
      chk("glitch_valid",   32'(valid), 32'h0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
      chk("f3c_done", 32'(done_cnt - d0), 32'd1);
      chk("f3c_data", 32'(cap_data), 32'h3C);
      chk("f3c_ferr", 32'(cap_ferr), 32'h0);
      read_pulse();
      repeat (BIT_CLKS) @(negedge clk);

      // Break: line low for 12 bit periods
      d0 = done_cnt;
      rx = 1'b0;
      repeat (12 * BIT_CLKS) @(negedge clk);
      chk("brk_done", 32'(done_cnt - d0), 32'd1);
      chk("brk_data", 32'(cap_data), 32'h00);
      chk("brk_ferr", 32'(cap_ferr), 32'h1);
      chk("brk_brk",  32'(cap_brk),  32'h1);
      chk("brk_perr", 32'(cap_perr), 32'h0);
      rx = 1'b1;
      repeat (12 * BIT_CLKS) @(negedge clk);
      chk("brk_idle", 32'(busy), 32'h0);
      read_pulse();
      chk("brk_read_clr", 32'(valid), 32'h0);

      // Back-to-back without read: overrun
      d0 = done_cnt;
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, -1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, -1);
      chk("ovr_done",  32'(done_cnt - d0), 32'd2);
      chk("ovr_data",  32'(data),  32'h22);
      chk("ovr_flag",  32'(ovr),   32'h1);
      chk("ovr_valid", 32'(valid), 32'h1);
      read_pulse();
      chk("ovr_read_valid", 32'(valid), 32'h0);
      chk("ovr_read_ovr",   32'(ovr),   32'h0);

      // Back-to-back with read in the second done cycle
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, -1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1, -1);
      chk("rdc_ovr",   32'(ovr),   32'h0);
      chk("rdc_valid", 32'(valid), 32'h1);
      chk("rdc_data",  32'(data),  32'h22);

      // Reset in the middle of DATA
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      chk("mid_busy", 32'(busy), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("midrst");
      rst = 1'b0;
      rx  = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk("post_rst_busy",  32'(busy),  32'h0);
      chk("post_rst_valid", 32'(valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
